// File: rtl/biriscv_csr_hpm_pkg.sv
// Address decode types and helpers for the performance-counter CSR block.
// Same guarded block as biriscv_defs.v so compile order of the two files does not matter.
`ifndef BIRISCV_DEFS_V
`define BIRISCV_DEFS_V
`define CSR_MCYCLE_ADDR     12'hB00
`define CSR_MCYCLEH_ADDR    12'hB80
`define CSR_MHPMEVENT_ADDR  12'h320
`define CSR_CYCLE_ADDR      12'hC00
`define CSR_CYCLEH_ADDR     12'hC80
`define CSR_MHPMOVF_ADDR    12'h7C0
`define CSR_MHPMOVFEN_ADDR  12'h7C1
`endif

package biriscv_csr_hpm_pkg;
  localparam logic [11:0] CSR_MCYCLE    = `CSR_MCYCLE_ADDR;
  localparam logic [11:0] CSR_MCYCLEH   = `CSR_MCYCLEH_ADDR;
  localparam logic [11:0] CSR_MHPMEVENT = `CSR_MHPMEVENT_ADDR;
  localparam logic [11:0] CSR_CYCLE     = `CSR_CYCLE_ADDR;
  localparam logic [11:0] CSR_CYCLEH    = `CSR_CYCLEH_ADDR;
  localparam logic [11:0] CSR_MHPMOVF   = `CSR_MHPMOVF_ADDR;
  localparam logic [11:0] CSR_MHPMOVFEN = `CSR_MHPMOVFEN_ADDR;

  typedef enum logic [3:0] {
    CSR_NONE, CSR_CNT_LO, CSR_CNT_HI, CSR_RO_LO, CSR_RO_HI,
    CSR_INHIBIT, CSR_EVENT, CSR_OVF, CSR_OVFEN
  } csr_region_e;

  typedef struct packed {
    csr_region_e region;
    logic [4:0]  idx;
  } csr_dec_t;

  function automatic csr_dec_t csr_decode(input logic [11:0] addr);
    csr_dec_t d;
    d.idx    = addr[4:0];
    d.region = CSR_NONE;
    if (addr[11:5] == CSR_MCYCLE[11:5])
      d.region = (d.idx == 5'd1) ? CSR_NONE : CSR_CNT_LO;
    else if (addr[11:5] == CSR_MCYCLEH[11:5])
      d.region = (d.idx == 5'd1) ? CSR_NONE : CSR_CNT_HI;
    else if (addr[11:5] == CSR_CYCLE[11:5])
      d.region = CSR_RO_LO;
    else if (addr[11:5] == CSR_CYCLEH[11:5])
      d.region = CSR_RO_HI;
    else if (addr[11:5] == CSR_MHPMEVENT[11:5])
      d.region = (d.idx == 5'd0) ? CSR_INHIBIT : (d.idx == 5'd1) ? CSR_NONE : CSR_EVENT;
    else if (addr == CSR_MHPMOVF)
      d.region = CSR_OVF;
    else if (addr == CSR_MHPMOVFEN)
      d.region = CSR_OVFEN;
    return d;
  endfunction

  // Bit i set when counter index i exists: mcycle, minstret and the hpm window.
  function automatic logic [31:0] impl_mask(input int nc);
    logic [31:0] m;
    m = 32'h5;
    for (int i = 3; i < 32; i++)
      if (i < 3 + nc) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/biriscv_defs.v
// CSR address map shared by the biriscv core and its hardware performance monitor.
`ifndef BIRISCV_DEFS_V
`define BIRISCV_DEFS_V
`define CSR_MCYCLE_ADDR     12'hB00
`define CSR_MCYCLEH_ADDR    12'hB80
`define CSR_MHPMEVENT_ADDR  12'h320
`define CSR_CYCLE_ADDR      12'hC00
`define CSR_CYCLEH_ADDR     12'hC80
`define CSR_MHPMOVF_ADDR    12'h7C0
`define CSR_MHPMOVFEN_ADDR  12'h7C1
`endif

// File: rtl/biriscv_hpm_counter.sv
// One 64-bit performance counter: half-word writes, small increment, wrap detect.
module biriscv_hpm_counter
  import biriscv_csr_hpm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o,
  output logic        ovf_o
);
  logic [63:0] cnt_q, cnt_d;
  logic [64:0] sum;

  // A write to either half suppresses the whole increment, including its carry.
  always_comb begin
    sum   = {1'b0, cnt_q} + {63'd0, inc_i};
    cnt_d = sum[63:0];
    ovf_o = sum[64];
    if (wr_lo_i || wr_hi_i) begin
      cnt_d = cnt_q;
      ovf_o = 1'b0;
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/biriscv_csr_hpm.sv
// Machine performance-monitor CSRs: mcycle, minstret, mhpmcounters, event select,
// inhibit, overflow status/enable and the registered overflow interrupt.
module biriscv_csr_hpm
  import biriscv_csr_hpm_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_EVENTS   = 8
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [11:0]           csr_raddr_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  input  logic                  csr_write_i,
  input  logic [11:0]           csr_waddr_i,
  input  logic [31:0]           csr_wdata_i,
  input  logic [1:0]            retire_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  interrupt_inhibit_i,
  output logic                  ovf_intr_o
);
  localparam int          EVT_W    = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] CNT_MASK = impl_mask(NUM_COUNTERS);
  localparam logic [31:0] HPM_MASK = CNT_MASK & ~32'h7;

  csr_dec_t rdec, wdec;
  assign rdec      = csr_decode(csr_raddr_i);
  assign wdec      = csr_decode(csr_waddr_i);
  assign csr_hit_o = (rdec.region != CSR_NONE);

  logic [63:0]             cnt [32];
  logic [31:0]             ovf_set;
  logic [31:0]             inhibit_q, inhibit_d, ovf_q, ovf_d, ovfen_q, ovfen_d;
  logic [31:0][EVT_W-1:0]  evt_q, evt_d;
  logic                    ovf_intr_q, ovf_intr_d;

  for (genvar i = 0; i < 32; i++) begin : g_cnt
    if (CNT_MASK[i]) begin : g_impl
      logic       ev_hit, wr_lo, wr_hi;
      logic [1:0] inc;

      always_comb begin
        ev_hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++)
          if (evt_q[i] == EVT_W'(k + 1) && event_i[k]) ev_hit = 1'b1;
      end

      assign inc   = inhibit_q[i] ? 2'd0 :
                     (i == 0)     ? 2'd1 :
                     (i == 2)     ? retire_i : {1'b0, ev_hit};
      assign wr_lo = csr_write_i && (wdec.region == CSR_CNT_LO) && (wdec.idx == 5'(i));
      assign wr_hi = csr_write_i && (wdec.region == CSR_CNT_HI) && (wdec.idx == 5'(i));

      biriscv_hpm_counter u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (inc),
        .wr_lo_i (wr_lo),
        .wr_hi_i (wr_hi),
        .wdata_i (csr_wdata_i),
        .cnt_o   (cnt[i]),
        .ovf_o   (ovf_set[i])
      );
    end else begin : g_none
      assign cnt[i]     = 64'd0;
      assign ovf_set[i] = 1'b0;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (rdec.region)
      CSR_CNT_LO, CSR_RO_LO: csr_rdata_o = cnt[rdec.idx][31:0];
      CSR_CNT_HI, CSR_RO_HI: csr_rdata_o = cnt[rdec.idx][63:32];
      CSR_INHIBIT:           csr_rdata_o = inhibit_q;
      CSR_EVENT:             csr_rdata_o = 32'(evt_q[rdec.idx]);
      CSR_OVF:               csr_rdata_o = ovf_q;
      CSR_OVFEN:             csr_rdata_o = ovfen_q;
      default:               csr_rdata_o = '0;
    endcase
  end

  // Clear is applied before set so a same-cycle overflow keeps its status bit.
  always_comb begin
    inhibit_d = inhibit_q;
    ovfen_d   = ovfen_q;
    evt_d     = evt_q;
    ovf_d     = ovf_q;
    if (csr_write_i) begin
      case (wdec.region)
        CSR_INHIBIT: inhibit_d = csr_wdata_i & CNT_MASK;
        CSR_OVFEN:   ovfen_d   = csr_wdata_i & CNT_MASK;
        CSR_OVF:     ovf_d     = ovf_q & ~csr_wdata_i;
        CSR_EVENT:   if (HPM_MASK[wdec.idx]) evt_d[wdec.idx] = csr_wdata_i[EVT_W-1:0];
        default:     ;
      endcase
    end
    ovf_d      = (ovf_d | ovf_set) & CNT_MASK;
    ovf_intr_d = (|(ovf_q & ovfen_q)) & ~interrupt_inhibit_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inhibit_q  <= '0;
      ovfen_q    <= '0;
      ovf_q      <= '0;
      evt_q      <= '0;
      ovf_intr_q <= 1'b0;
    end else begin
      inhibit_q  <= inhibit_d;
      ovfen_q    <= ovfen_d;
      ovf_q      <= ovf_d;
      evt_q      <= evt_d;
      ovf_intr_q <= ovf_intr_d;
    end
  end

  assign ovf_intr_o = ovf_intr_q;
endmodule

// File: tb/tb_biriscv_csr_hpm.sv
// Directed bench: read expectations go into a scoreboard, a negedge monitor compares.
module tb_biriscv_csr_hpm;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] csr_raddr_i, csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_write_i;
  logic [1:0]  retire_i;
  logic [7:0]  event_i;
  logic        interrupt_inhibit_i;
  logic [31:0] rdata, rdata1;
  logic        hit, hit1, intr, intr1;
  logic        rd_vld = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
    logic        chk_intr;
    logic        intr;
    logic        dut1;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk_i = ~clk_i;

  biriscv_csr_hpm #(.NUM_COUNTERS(4), .NUM_EVENTS(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_raddr_i(csr_raddr_i), .csr_rdata_o(rdata),
    .csr_hit_o(hit), .csr_write_i(csr_write_i), .csr_waddr_i(csr_waddr_i),
    .csr_wdata_i(csr_wdata_i), .retire_i(retire_i), .event_i(event_i),
    .interrupt_inhibit_i(interrupt_inhibit_i), .ovf_intr_o(intr)
  );

  biriscv_csr_hpm #(.NUM_COUNTERS(1), .NUM_EVENTS(8)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .csr_raddr_i(csr_raddr_i), .csr_rdata_o(rdata1),
    .csr_hit_o(hit1), .csr_write_i(csr_write_i), .csr_waddr_i(csr_waddr_i),
    .csr_wdata_i(csr_wdata_i), .retire_i(retire_i), .event_i(event_i),
    .interrupt_inhibit_i(interrupt_inhibit_i), .ovf_intr_o(intr1)
  );

  // Monitor
  always @(negedge clk_i) begin
    if (rd_vld) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: read presented with no expectation queued");
      end else begin
        exp_t e;
        logic [31:0] ad;
        logic ah, ai;
        e  = sb.pop_front();
        ad = e.dut1 ? rdata1 : rdata;
        ah = e.dut1 ? hit1 : hit;
        ai = e.dut1 ? intr1 : intr;
        n_cmp++;
        if (ad !== e.data) begin
          n_bad++;
          $display("FAIL %s: rdata=%h expected %h", e.name, ad, e.data);
        end
        n_cmp++;
        if (ah !== e.hit) begin
          n_bad++;
          $display("FAIL %s_hit: hit=%b expected %b", e.name, ah, e.hit);
        end
        if (e.chk_intr) begin
          n_cmp++;
          if (ai !== e.intr) begin
            n_bad++;
            $display("FAIL %s_intr: ovf_intr=%b expected %b", e.name, ai, e.intr);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_write_i = 1'b1; csr_waddr_i = a; csr_wdata_i = d;
    tick();
    csr_write_i = 1'b0;
  endtask

  // Presents a read for one cycle; the monitor samples it on the following negedge.
  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic h,
                    input string nm, input logic u1 = 1'b0,
                    input logic ci = 1'b0, input logic iv = 1'b0);
    exp_t e;
    e.name = nm; e.data = d; e.hit = h; e.chk_intr = ci; e.intr = iv; e.dut1 = u1;
    csr_raddr_i = a;
    sb.push_back(e);
    rd_vld = 1'b1;
    tick();
    rd_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ret_pat [10];
    logic [7:0] ev_pat [8];
    ret_pat = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2};
    ev_pat  = '{8'h02, 8'h01, 8'h02, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
    rst_i = 1'b1; csr_raddr_i = '0; csr_waddr_i = '0; csr_wdata_i = '0;
    csr_write_i = 1'b0; retire_i = '0; event_i = '0; interrupt_inhibit_i = 1'b0;
    tick(); tick();

    // Reset state
    rd(12'hB00, 32'd0, 1'b1, "rst_mcycle", 1'b0, 1'b1, 1'b0);
    rd(12'h7C0, 32'd0, 1'b1, "rst_ovf");
    rd(12'h7C1, 32'd0, 1'b1, "rst_ovfen");
    rd(12'hB01, 32'd0, 1'b0, "hit_b01");

    // Free running after release
    rst_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      retire_i = ret_pat[c];
      tick();
    end
    retire_i = '0;
    rd(12'hB00, 32'd10, 1'b1, "mcycle_10");
    rd(12'hB02, 32'd15, 1'b1, "minstret_sum");
    rd(12'hC82, 32'd0,  1'b1, "instreth_shadow");

    // minstret carry into the high half; shadow writes ignored
    wr(12'hB02, 32'hFFFF_FFFF);
    retire_i = 2'd2; tick(); retire_i = '0;
    rd(12'hB02, 32'd1, 1'b1, "minstret_carry_lo");
    rd(12'hB82, 32'd1, 1'b1, "minstret_carry_hi");
    wr(12'hC02, 32'd5);
    rd(12'hC02, 32'd1, 1'b1, "shadow_wr_ignored");

    // Event selects: out-of-range select counts nothing, upper bits read zero
    wr(12'h324, 32'd9);
    event_i = 8'hFF; tick(); tick(); event_i = '0;
    rd(12'hB04, 32'd0, 1'b1, "evt_out_of_range");
    rd(12'h324, 32'd9, 1'b1, "evt4_readback");
    wr(12'h325, 32'hFFFF_FFF3);
    rd(12'h325, 32'd3, 1'b1, "evt5_width");

    wr(12'h323, 32'd2);
    for (int c = 0; c < 8; c++) begin
      event_i = ev_pat[c];
      tick();
    end
    event_i = '0;
    rd(12'hB03, 32'd5, 1'b1, "hpm3_event1_count");

    // Overflow and interrupt
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    wr(12'h7C1, 32'h8);
    rd(12'hB83, 32'hFFFF_FFFF, 1'b1, "hpm3h_allones");
    event_i = 8'h02; tick(); event_i = '0;
    rd(12'hB03, 32'd0, 1'b1, "hpm3_wrap", 1'b0, 1'b1, 1'b0);
    rd(12'h7C0, 32'h8, 1'b1, "ovf3_set", 1'b0, 1'b1, 1'b1);
    interrupt_inhibit_i = 1'b1; tick();
    rd(12'h7C0, 32'h8, 1'b1, "intr_inhibited", 1'b0, 1'b1, 1'b0);
    rd(12'h7C0, 32'h8, 1'b1, "intr_stays_low", 1'b0, 1'b1, 1'b0);
    interrupt_inhibit_i = 1'b0;

    // W1C, write beating increment, set beating clear
    wr(12'h7C0, 32'h8);
    rd(12'h7C0, 32'h0, 1'b1, "ovf_w1c");
    wr(12'hB03, 32'hFFFF_FFFF);
    csr_write_i = 1'b1; csr_waddr_i = 12'hB83; csr_wdata_i = 32'hFFFF_FFFF; event_i = 8'h02;
    tick();
    csr_write_i = 1'b0; event_i = '0;
    rd(12'hB03, 32'hFFFF_FFFF, 1'b1, "write_beats_inc");
    rd(12'h7C0, 32'h0, 1'b1, "write_no_ovf");
    csr_write_i = 1'b1; csr_waddr_i = 12'h7C0; csr_wdata_i = 32'h8; event_i = 8'h02;
    tick();
    csr_write_i = 1'b0; event_i = '0;
    rd(12'h7C0, 32'h8, 1'b1, "set_beats_clear");
    rd(12'hB83, 32'h0, 1'b1, "hpm3h_wrapped");
    wr(12'h7C0, 32'h8);
    rd(12'h7C0, 32'h0, 1'b1, "ovf_cleared_again");

    // mcycle write and inhibit timing
    wr(12'hB00, 32'h100);
    rd(12'hB00, 32'h100, 1'b1, "mcycle_written");
    rd(12'hB00, 32'h101, 1'b1, "mcycle_resume");
    wr(12'h320, 32'h1);
    rd(12'hB00, 32'h103, 1'b1, "inhibit_prewrite_inc");
    rd(12'hB00, 32'h103, 1'b1, "mcycle_frozen");
    wr(12'h320, 32'h0);
    rd(12'hB00, 32'h103, 1'b1, "uninhibit_cycle");
    rd(12'hB00, 32'h104, 1'b1, "mcycle_counting");

    // Single-counter instance and read-only shadow
    wr(12'hB04, 32'h55);
    rd(12'hB04, 32'h55, 1'b1, "hpm4_written");
    rd(12'hB04, 32'h0,  1'b1, "nc1_b04_zero", 1'b1);
    wr(12'hB03, 32'h1234);
    wr(12'hC03, 32'h77);
    rd(12'hB03, 32'h1234, 1'b1, "c03_wr_ignored");
    rd(12'hC03, 32'h1234, 1'b1, "nc1_c03_shadow", 1'b1);
    rd(12'hB1F, 32'h0, 1'b1, "unimpl_b1f");
    rd(12'h7C2, 32'h0, 1'b0, "hit_7c2");

    // Implemented-bit masks
    wr(12'h7C1, 32'hFFFF_FFFF);
    rd(12'h7C1, 32'h7D, 1'b1, "ovfen_mask");
    rd(12'h7C1, 32'h0D, 1'b1, "nc1_ovfen_mask", 1'b1);
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h7D, 1'b1, "inhibit_mask");

    // Reset during a pending write
    csr_write_i = 1'b1; csr_waddr_i = 12'hB03; csr_wdata_i = 32'hAAAA;
    rst_i = 1'b1;
    tick();
    csr_write_i = 1'b0; rst_i = 1'b0;
    rd(12'hB03, 32'h0, 1'b1, "rst_discard_wr", 1'b0, 1'b1, 1'b0);
    rd(12'h320, 32'h0, 1'b1, "rst_inhibit");
    rd(12'h7C1, 32'h0, 1'b1, "rst_ovfen2");

    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/biriscv_csr_hpm.md
BIRISCV_CSR_HPM -- requirements
Module: biriscv_csr_hpm

Interface
REQ-001 SHALL provide parameter NUM_COUNTERS, default 4, meaning number of implemented mhpmcounters (legal 1..29), indices 3..3+NUM_COUNTERS-1.
REQ-002 SHALL provide parameter NUM_EVENTS, default 8, meaning width of event input vector (legal 1..255).
REQ-003 SHALL use reset rst_i, asynchronous, active-high; clock clk_i.
REQ-004 Ports (name direction width meaning):
clk_i  in  1  clock
rst_i  in  1  async active-high reset
csr_raddr_i  in  12  CSR read address (issue stage)
csr_rdata_o  out  32  read data, combinational
csr_hit_o  out  1  csr_raddr_i decodes to a CSR owned by this block
csr_write_i  in  1  writeback CSR write strobe
csr_waddr_i  in  12  writeback CSR address
csr_wdata_i  in  32  writeback CSR data
retire_i  in  2  instructions retired this cycle (0..2, dual issue)
event_i  in  NUM_EVENTS  per-cycle event pulses
interrupt_inhibit_i  in  1  suppress interrupt launch
ovf_intr_o  out  1  registered counter-overflow interrupt request

Function
REQ-005 SHALL implement 64-bit counters mcycle (index 0), minstret (index 2), mhpmcounter[3..3+NUM_COUNTERS-1].
REQ-006 SHALL map: mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, mhpmcounterN/h 0xB00+N/0xB80+N, mhpmeventN 0x320+N, mcountinhibit 0x320, mhpmovf 0x7C0, mhpmovfen 0x7C1; read-only shadows 0xC00-0xC1F / 0xC80-0xC9F read same values, writes ignored.
REQ-007 SHALL assert csr_hit_o for every address in REQ-006 for indices 0..31 (index 1 excluded at 0xB01/0xB81/0x321); unimplemented indices read zero, writes ignored.
REQ-008 mcycle SHALL increment by 1 each cycle unless mcountinhibit[0]=1.
REQ-009 minstret SHALL increment by retire_i (value 3 treated as 3, no clamp) unless mcountinhibit[2]=1.
REQ-010 mhpmeventN SHALL hold EVT_W=clog2(NUM_EVENTS+1) bits, upper bits read 0; value 0 or >NUM_EVENTS counts nothing; value k counts +1 per cycle event_i[k-1]=1, unless mcountinhibit[N]=1.
REQ-011 mcountinhibit SHALL implement bits 0, 2, 3..3+NUM_COUNTERS-1; others read 0.
REQ-012 Writes SHALL take effect at the next clock edge; increments in the write cycle use pre-write control values.
REQ-013 Write to low/high half SHALL replace only those 32 bits; a write to a counter half SHALL win over that cycle's increment for the whole 64-bit counter (no increment, no overflow that cycle).
REQ-014 Increment from 0xFFFF_FFFF_FFFF_FFFF SHALL wrap to 0 (minstret: modulo 2^64 with carry) and set mhpmovf[idx] in the same edge.
REQ-015 mhpmovf SHALL be write-1-to-clear; simultaneous set and clear of the same bit SHALL leave it set.
REQ-016 ovf_intr_o SHALL register |(mhpmovf & mhpmovfen) & ~interrupt_inhibit_i, one-cycle latency.
REQ-017 mhpmovfen SHALL be read/write on implemented bit positions only.

Reset
REQ-018 On rst_i: all counters 0, mhpmevent 0, mcountinhibit 0, mhpmovf 0, mhpmovfen 0, ovf_intr_o 0; counting resumes first edge after deassertion.
REQ-019 Reset mid-operation SHALL discard any in-flight write.

Structure
REQ-020 CSR addresses (0xB00, 0xB80, 0x320, 0xC00, 0xC80, 0x7C0, 0x7C1) SHALL be defines in biriscv_defs.v.
REQ-021 One sub-module biriscv_hpm_counter (64-bit counter, write-half, increment, overflow flag) SHALL be instantiated per counter via generate.

Verification
REQ-022 Reset release, no writes: after 10 cycles mcycle=10, minstret=sum(retire_i), csr_hit_o=1 at 0xB00, 0 at 0xB01.
REQ-023 Write mhpmevent3=2, pulse event_i[1] 5 cycles -> mhpmcounter3 reads 5; event_i[0] pulses not counted.
REQ-024 Write mhpmcounter3=0xFFFFFFFF, mhpmcounter3h=0xFFFFFFFF, mhpmovfen=0x8, one event -> counter=0, mhpmovf[3]=1, ovf_intr_o=1 next cycle; with interrupt_inhibit_i=1 -> stays 0.
REQ-025 Write mcountinhibit=0x1 -> mcycle frozen from next cycle; write 0 -> resumes; write mcycle=0x100 during increment -> reads 0x100 then 0x101.
REQ-026 Write 0x8 to mhpmovf same cycle as new overflow on counter 3 -> bit remains 1; next write clears it.
REQ-027 NUM_COUNTERS=1: 0xB04 read 0, hit=1, write ignored; 0xC03 write ignored.
